// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: start + DATA_BITS (LSB first) [+ parity] + stop.
// Optional parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int DATA_BITS     = 8,
  parameter int STOP_BIT_TICK = 16,
  parameter int PARITY_ODD    = 0
) (
  input  logic                 clk_50MHz,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done_tick,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int TW = (STOP_BIT_TICK > 1) ? $clog2(STOP_BIT_TICK) : 1;
  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(STOP_BIT_TICK / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STOP_BIT_TICK - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [NW-1:0]          nbits_q, nbits_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   fe_q, fe_d;
  logic                   rx_meta, rx_sync;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   pe_q, pe_d;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != 1'(PARITY_ODD);
  endfunction
`endif

  // rx synchronizer stage, idle-high so reset never looks like a start bit
  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      nbits_q <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      nbits_q <= nbits_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    nbits_d = nbits_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    fe_d    = fe_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = pe_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (!rx_sync) begin
          state_d = S_START;
          tick_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (tick_q == TICK_HALF) begin
            if (!rx_sync) begin
              state_d = S_DATA;
              tick_d  = '0;
              nbits_d = '0;
            end else begin
              // start bit vanished before mid-bit: treat as line noise
              state_d = S_IDLE;
              tick_d  = '0;
              busy_d  = 1'b0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            shreg_d = {rx_sync, shreg_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (nbits_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              nbits_d = nbits_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            par_d   = rx_sync;
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (sample_tick) begin
          if (tick_q == TICK_LAST) begin
            // leave mid stop bit so a back-to-back start edge is not missed
            data_d  = shreg_q;
            done_d  = 1'b1;
            fe_d    = ~rx_sync;
`ifdef UART_RX_PARITY_EN
            pe_d    = parity_mismatch(shreg_q, par_q);
`endif
            tick_d  = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign data_out     = data_q;
  assign rx_done_tick = done_q;
  assign rx_busy      = busy_q;
  assign frame_err    = fe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = pe_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver (8 data bits, 16x oversampling,
// sample_tick every 27 clocks). Parity steps run when UART_RX_PARITY_EN is defined.
module tb_uart_receiver;

  localparam int TICK_CLKS = 27;
  localparam int BIT_CLKS  = 16 * TICK_CLKS;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME_TICKS = 8 + 16 * (8 + PB + 1);
  localparam int BREAK_CLKS  = (2 * FRAME_TICKS + 4) * TICK_CLKS;

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       rx_done_tick, rx_busy, frame_err, parity_err;

  int checks = 0;
  int failures = 0;
  int tcnt = 0;
  int done_cnt = 0;
  int base;
  logic [7:0] hist_d  [64];
  logic       hist_fe [64];
  logic       hist_pe [64];

  uart_receiver #(.DATA_BITS(8), .STOP_BIT_TICK(16), .PARITY_ODD(0)) dut (
    .clk_50MHz   (clk_50MHz),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .data_out    (data_out),
    .rx_done_tick(rx_done_tick),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz) begin
    if (tcnt == TICK_CLKS - 1) begin
      tcnt <= 0;
      sample_tick <= 1'b1;
    end else begin
      tcnt <= tcnt + 1;
      sample_tick <= 1'b0;
    end
  end

  always @(negedge clk_50MHz) begin
    if (rx_done_tick) begin
      hist_d[done_cnt % 64]  = data_out;
      hist_fe[done_cnt % 64] = frame_err;
      hist_pe[done_cnt % 64] = parity_err;
      done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pbit, input logic stopv, input int stop_len);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_50MHz);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk_50MHz);
    end
`ifdef UART_RX_PARITY_EN
    rx = pbit;
    repeat (BIT_CLKS) @(negedge clk_50MHz);
`endif
    rx = stopv;
    repeat (stop_len) @(negedge clk_50MHz);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d);
    send(d, ^d, 1'b1, BIT_CLKS);
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * BIT_CLKS) @(negedge clk_50MHz);
  endtask

  initial begin
    repeat (4) @(negedge clk_50MHz);
    check("rst_data_out", data_out, 8'h00);
    check("rst_done", rx_done_tick, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    reset = 1'b1;
    idle(1);

    // single good frame
    base = done_cnt;
    send_good(8'hA5);
    check("a5_count", done_cnt - base, 1);
    check("a5_data", hist_d[base % 64], 8'hA5);
    check("a5_fe", hist_fe[base % 64], 1'b0);
    check("a5_busy_after", rx_busy, 1'b0);
    idle(1);

    // start-bit glitch of 4 ticks
    base = done_cnt;
    rx = 1'b0;
    repeat (4 * TICK_CLKS) @(negedge clk_50MHz);
    check("glitch_busy_during", rx_busy, 1'b1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_50MHz);
    check("glitch_count", done_cnt - base, 0);
    check("glitch_busy_after", rx_busy, 1'b0);
    check("glitch_data_held", data_out, 8'hA5);
    base = done_cnt;
    send_good(8'h5A);
    check("5a_count", done_cnt - base, 1);
    check("5a_data", hist_d[base % 64], 8'h5A);
    idle(1);

    // stop bit low, released before a stale start could be confirmed
    base = done_cnt;
    send(8'h3C, ^8'h3C, 1'b0, 300);
    repeat (BIT_CLKS) @(negedge clk_50MHz);
    check("3c_count", done_cnt - base, 1);
    check("3c_data", hist_d[base % 64], 8'h3C);
    check("3c_fe", hist_fe[base % 64], 1'b1);
    check("3c_fe_held", frame_err, 1'b1);
    base = done_cnt;
    send_good(8'h01);
    check("01_data", hist_d[base % 64], 8'h01);
    check("01_fe_cleared", frame_err, 1'b0);
    idle(1);

    // break: two full frames of zeros, released while the third is in START
    base = done_cnt;
    rx = 1'b0;
    repeat (BREAK_CLKS) @(negedge clk_50MHz);
    idle(2);
    check("brk_count", done_cnt - base, 2);
    check("brk_data0", hist_d[base % 64], 8'h00);
    check("brk_fe0", hist_fe[base % 64], 1'b1);
    check("brk_fe1", hist_fe[(base + 1) % 64], 1'b1);
    check("brk_busy_after", rx_busy, 1'b0);

    // back-to-back frames, no idle gap
    base = done_cnt;
    send_good(8'h00);
    send_good(8'hFF);
    idle(1);
    check("b2b_count", done_cnt - base, 2);
    check("b2b_data0", hist_d[base % 64], 8'h00);
    check("b2b_data1", hist_d[(base + 1) % 64], 8'hFF);
    check("b2b_fe0", hist_fe[base % 64], 1'b0);
    check("b2b_fe1", hist_fe[(base + 1) % 64], 1'b0);
    check("b2b_pe1", hist_pe[(base + 1) % 64], 1'b0);

    // one-clock reset during bit 3 of 0x77
    base = done_cnt;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_50MHz);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk_50MHz);
    end
    rx = 1'b0;
    repeat (200) @(negedge clk_50MHz);
    reset = 1'b0;
    rx = 1'b1;
    @(posedge clk_50MHz);
    #1;
    check("mrst_data_out", data_out, 8'h00);
    check("mrst_busy", rx_busy, 1'b0);
    check("mrst_done", rx_done_tick, 1'b0);
    check("mrst_fe", frame_err, 1'b0);
    @(negedge clk_50MHz);
    reset = 1'b1;
    idle(2);
    check("mrst_no_pulse", done_cnt - base, 0);
    base = done_cnt;
    send_good(8'h81);
    check("81_count", done_cnt - base, 1);
    check("81_data", hist_d[base % 64], 8'h81);
    idle(1);

`ifdef UART_RX_PARITY_EN
    base = done_cnt;
    send(8'h07, 1'b1, 1'b1, BIT_CLKS);
    check("par_ok_count", done_cnt - base, 1);
    check("par_ok_pe", hist_pe[base % 64], 1'b0);
    idle(1);
    base = done_cnt;
    send(8'h07, 1'b0, 1'b1, BIT_CLKS);
    check("par_bad_count", done_cnt - base, 1);
    check("par_bad_pe", hist_pe[base % 64], 1'b1);
    check("par_bad_data", hist_d[base % 64], 8'h07);
    check("par_bad_fe", hist_fe[base % 64], 1'b0);
    idle(1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
